// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The arbiter, the lane-alignment logic and the surrounding core all import this package.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_INST_BUSY = 2'd1,
      ARB_DATA_BUSY = 2'd2,
      ARB_RESP      = 2'd3
   } arbState_e;

   // Encoding of data_rd_wr_ctrl; 2'b11 has no member and is treated as illegal.
   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } memSize_e;

   localparam logic [31:0] MEM_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [3:0]  BE_FULL             = 4'b1111;

   typedef union packed {
      logic [31:0]      word;
      logic [1:0][15:0] half;
      logic [3:0][7:0]  byte_lane;
   } dataBus_u;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instrFields_t;

   typedef union packed {
      logic [31:0]  raw;
      instrFields_t fields;
   } instruction_u;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane logic for the data port: byte enables, store replication,
// load alignment and misalignment detection. Purely combinational.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  inst_addr_lo_i,
   input  logic [31:0] wr_data_i,
   input  logic [1:0]  rd_offset_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        data_misalign_o,
   output logic        inst_misalign_o
);

   dataBus_u wr_bus;
   dataBus_u rep_bus;

   always_comb begin
      wr_bus.word  = wr_data_i;
      rep_bus.word = wr_data_i;
      be_o         = BE_FULL;
      case (size_i)
         MEM_BYTE: begin
            be_o         = 4'b0001 << addr_lo_i;
            rep_bus.word = {4{wr_bus.byte_lane[0]}};
         end
         MEM_HALF: begin
            be_o         = 4'b0011 << addr_lo_i;
            rep_bus.word = {2{wr_bus.half[0]}};
         end
         default: begin
            be_o         = BE_FULL;
            rep_bus.word = wr_bus.word;
         end
      endcase
      wdata_o = rep_bus.word;
   end

   always_comb begin
      case (size_i)
         MEM_BYTE: data_misalign_o = 1'b0;
         MEM_HALF: data_misalign_o = addr_lo_i[0];
         MEM_WORD: data_misalign_o = (addr_lo_i != 2'b00);
         default:  data_misalign_o = 1'b1;
      endcase
   end

   assign inst_misalign_o = (inst_addr_lo_i != 2'b00);

   // Offset is the one latched at grant, so a requester that moves its address mid-cycle is harmless.
   assign rdata_o = rdata_i >> {rd_offset_i, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one
// memory request/ack bus, with round-robin or data-priority, timeout and misalignment errors.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit RR_EN          = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        inst_rd_en,
   input  logic [31:0] inst_addr,
   output logic        inst_ready,
   output logic [31:0] inst_data,
   input  logic        data_rd_en,
   input  logic        data_wr_en,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr,
   input  logic [1:0]  data_rd_wr_ctrl,
   output logic        data_ready,
   output logic [31:0] data_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        bus_error
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   arbState_e    state_q, state_d;
   logic [15:0]  count_q, count_d;
   logic         last_data_q, last_data_d;
   logic [1:0]   offset_q, offset_d;
   logic         is_write_q, is_write_d;
   logic         mem_req_q, mem_req_d;
   logic         mem_we_q, mem_we_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic [3:0]   mem_be_q, mem_be_d;
   logic [31:0]  mem_wdata_q, mem_wdata_d;
   logic         inst_ready_q, inst_ready_d;
   logic         data_ready_q, data_ready_d;
   logic         bus_error_q, bus_error_d;
   instruction_u inst_data_q, inst_data_d;
   logic [31:0]  data_rd_q, data_rd_d;

   logic [3:0]   lane_be;
   logic [31:0]  lane_wdata;
   logic [31:0]  lane_rdata;
   logic         data_misalign;
   logic         inst_misalign;
   logic         data_pend;
   logic         grant_data;
   logic         grant_inst;
   logic [15:0]  count_inc;
   logic         timeout_hit;

   mem_lane_align u_lane (
      .size_i          (data_rd_wr_ctrl),
      .addr_lo_i       (data_addr[1:0]),
      .inst_addr_lo_i  (inst_addr[1:0]),
      .wr_data_i       (data_wr),
      .rd_offset_i     (offset_q),
      .rdata_i         (mem_rdata),
      .be_o            (lane_be),
      .wdata_o         (lane_wdata),
      .rdata_o         (lane_rdata),
      .data_misalign_o (data_misalign),
      .inst_misalign_o (inst_misalign)
   );

   // On a tie, data wins unless it was the last one served (or always, without round-robin).
   assign data_pend   = data_rd_en | data_wr_en;
   assign grant_data  = data_pend & (~inst_rd_en | ~RR_EN | ~last_data_q);
   assign grant_inst  = inst_rd_en & ~grant_data;
   assign count_inc   = count_q + 16'd1;
   assign timeout_hit = (count_inc == TIMEOUT_LIMIT);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      last_data_d  = last_data_q;
      offset_d     = offset_q;
      is_write_d   = is_write_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
      bus_error_d  = 1'b0;
      inst_data_d  = inst_data_q;
      data_rd_d    = data_rd_q;

      case (state_q)
         ARB_IDLE: begin
            if (grant_data) begin
               last_data_d = 1'b1;
               count_d     = 16'd0;
               offset_d    = data_addr[1:0];
               is_write_d  = data_wr_en;
               if (data_misalign) begin
                  state_d      = ARB_RESP;
                  data_ready_d = 1'b1;
                  bus_error_d  = 1'b1;
                  data_rd_d    = 32'd0;
               end else begin
                  state_d     = ARB_DATA_BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = data_wr_en;
                  mem_addr_d  = data_addr & MEM_ADDR_ALIGN_MASK;
                  mem_be_d    = lane_be;
                  mem_wdata_d = lane_wdata;
               end
            end else if (grant_inst) begin
               last_data_d = 1'b0;
               count_d     = 16'd0;
               if (inst_misalign) begin
                  state_d          = ARB_RESP;
                  inst_ready_d     = 1'b1;
                  bus_error_d      = 1'b1;
                  inst_data_d.raw  = 32'd0;
               end else begin
                  state_d     = ARB_INST_BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = inst_addr & MEM_ADDR_ALIGN_MASK;
                  mem_be_d    = BE_FULL;
                  mem_wdata_d = 32'd0;
               end
            end
         end

         ARB_INST_BUSY: begin
            count_d = count_inc;
            if (mem_ack) begin
               state_d         = ARB_RESP;
               mem_req_d       = 1'b0;
               inst_ready_d    = 1'b1;
               inst_data_d.raw = mem_rdata;
            end else if (timeout_hit) begin
               state_d         = ARB_RESP;
               mem_req_d       = 1'b0;
               inst_ready_d    = 1'b1;
               bus_error_d     = 1'b1;
               inst_data_d.raw = 32'd0;
            end
         end

         ARB_DATA_BUSY: begin
            count_d = count_inc;
            if (mem_ack) begin
               state_d      = ARB_RESP;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               data_ready_d = 1'b1;
               if (!is_write_q) begin
                  data_rd_d = lane_rdata;
               end
            end else if (timeout_hit) begin
               state_d      = ARB_RESP;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               data_ready_d = 1'b1;
               bus_error_d  = 1'b1;
               data_rd_d    = 32'd0;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         count_q      <= 16'd0;
         last_data_q  <= 1'b0;
         offset_q     <= 2'd0;
         is_write_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_be_q     <= 4'd0;
         mem_wdata_q  <= 32'd0;
         inst_ready_q <= 1'b0;
         data_ready_q <= 1'b0;
         bus_error_q  <= 1'b0;
         inst_data_q  <= '0;
         data_rd_q    <= 32'd0;
      end else if (clk_en) begin
         state_q      <= state_d;
         count_q      <= count_d;
         last_data_q  <= last_data_d;
         offset_q     <= offset_d;
         is_write_q   <= is_write_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_ready_q <= inst_ready_d;
         data_ready_q <= data_ready_d;
         bus_error_q  <= bus_error_d;
         inst_data_q  <= inst_data_d;
         data_rd_q    <= data_rd_d;
      end
   end

   assign inst_ready = inst_ready_q;
   assign inst_data  = inst_data_q.raw;
   assign data_ready = data_ready_q;
   assign data_rd    = data_rd_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter; expectations come from a
// transaction-level model of lanes, arbitration order and timeout latency.
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        inst_rd_en;
   logic [31:0] inst_addr;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic        data_rd_en;
   logic        data_wr_en;
   logic [31:0] data_addr;
   logic [31:0] data_wr;
   logic [1:0]  data_rd_wr_ctrl;
   logic        data_ready;
   logic [31:0] data_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_error;

   int n_checks = 0;
   int n_fail   = 0;
   int txn_id   = 0;
   bit last_data = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .RR_EN(1'b1)) dut (
      .clk             (clk),
      .rst             (rst),
      .clk_en          (clk_en),
      .inst_rd_en      (inst_rd_en),
      .inst_addr       (inst_addr),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .data_rd_en      (data_rd_en),
      .data_wr_en      (data_wr_en),
      .data_addr       (data_addr),
      .data_wr         (data_wr),
      .data_rd_wr_ctrl (data_rd_wr_ctrl),
      .data_ready      (data_ready),
      .data_rd         (data_rd),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_be          (mem_be),
      .mem_wdata       (mem_wdata),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .bus_error       (bus_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit model_data_mis(input logic [31:0] a, input logic [1:0] sz);
      case (sz)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b10:   return a[1:0] != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] one   = 4'b0001;
      logic [3:0] three = 4'b0011;
      case (sz)
         2'b00:   return one << off;
         2'b01:   return three << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   return {24'd0, d[7:0]} * 32'h0101_0101;
         2'b01:   return {16'd0, d[15:0]} * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   task automatic set_inst(input logic [31:0] a);
      inst_addr  = a;
      inst_rd_en = 1'b1;
   endtask

   task automatic set_data(input bit wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      data_addr       = a;
      data_rd_wr_ctrl = sz;
      data_wr         = d;
      data_rd_en      = ~wr;
      data_wr_en      = wr;
   endtask

   task automatic rand_inst();
      logic [31:0] a;
      a = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      set_inst(a);
   endtask

   task automatic rand_data();
      int          s;
      logic [1:0]  sz;
      logic [31:0] a;
      s  = $urandom_range(0, 9);
      sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
      a  = 32'h2000_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
      set_data($urandom_range(0, 1) == 1, a, sz, $urandom);
   endtask

   // Serve one grant to the named requester; its request must already be driven.
   task automatic serve(input bit is_inst, input int ack_at, input logic [31:0] rdata, input bit stall);
      bit          mis, to, wr;
      logic [31:0] exp_addr, exp_rd;
      logic [3:0]  exp_be;
      int          last;
      string       who;
      who = is_inst ? "inst" : "data";
      wr  = !is_inst && data_wr_en;
      if (is_inst) begin
         mis      = inst_addr[1:0] != 2'b00;
         exp_addr = {inst_addr[31:2], 2'b00};
         exp_be   = 4'b1111;
      end else begin
         mis      = model_data_mis(data_addr, data_rd_wr_ctrl);
         exp_addr = {data_addr[31:2], 2'b00};
         exp_be   = model_be(data_rd_wr_ctrl, data_addr[1:0]);
      end
      to     = !mis && (ack_at > TO);
      exp_rd = (mis || to) ? 32'd0 : (is_inst ? rdata : rdata >> (8 * data_addr[1:0]));
      last_data = !is_inst;

      step();
      if (mis) begin
         check({who, "_mis_no_req"}, 32'(mem_req), 32'd0);
      end else begin
         check({who, "_req"},  32'(mem_req), 32'd1);
         check({who, "_addr"}, mem_addr, exp_addr);
         check({who, "_be"},   32'(mem_be), 32'(exp_be));
         check({who, "_we"},   32'(mem_we), 32'(wr));
         if (wr) check({who, "_wdata"}, mem_wdata, model_wdata(data_rd_wr_ctrl, data_wr));
         last = to ? TO : ack_at;
         for (int n = 1; n <= last; n++) begin
            if (n > 1) check({who, "_busy_req"}, 32'(mem_req), 32'd1);
            check({who, "_busy_rdy"}, 32'(is_inst ? inst_ready : data_ready), 32'd0);
            if (stall && n == 1) begin
               clk_en    = 1'b0;
               mem_ack   = 1'b1;
               mem_rdata = $urandom;
               step();
               step();
               check({who, "_stall_req"}, 32'(mem_req), 32'd1);
               check({who, "_stall_rdy"}, 32'(is_inst ? inst_ready : data_ready), 32'd0);
               clk_en = 1'b1;
            end
            mem_ack   = (n == ack_at);
            mem_rdata = (n == ack_at) ? rdata : $urandom;
            step();
         end
         mem_ack = 1'b0;
         check({who, "_resp_req"}, 32'(mem_req), 32'd0);
      end
      check({who, "_ready"}, 32'(is_inst ? inst_ready : data_ready), 32'd1);
      check({who, "_other_ready"}, 32'(is_inst ? data_ready : inst_ready), 32'd0);
      check({who, "_bus_error"}, 32'(bus_error), 32'(mis || to));
      if (is_inst) check("inst_data", inst_data, exp_rd);
      else if (!wr || mis || to) check("data_rd", data_rd, exp_rd);
      $display("txn %0d %s addr=0x%08h ack_at=%0d misalign=%0d timeout=%0d stall=%0d",
               txn_id, who, is_inst ? inst_addr : data_addr, ack_at, mis, to, stall);
      txn_id++;

      if (is_inst) inst_rd_en = 1'b0;
      else begin
         data_rd_en = 1'b0;
         data_wr_en = 1'b0;
      end
      mem_ack = ($urandom_range(0, 1) == 1);
      step();
      mem_ack = 1'b0;
      check({who, "_idle_irdy"}, 32'(inst_ready), 32'd0);
      check({who, "_idle_drdy"}, 32'(data_ready), 32'd0);
      check({who, "_idle_err"},  32'(bus_error), 32'd0);
      check({who, "_idle_req"},  32'(mem_req), 32'd0);
   endtask

   // Both requesters held; the winner re-requests after each grant.
   task automatic pair_rounds(input int rounds);
      bit w_inst;
      rand_inst();
      rand_data();
      w_inst = 1'b0;
      for (int r = 0; r < rounds; r++) begin
         w_inst = last_data;
         serve(w_inst, $urandom_range(1, TO + 2), $urandom, $urandom_range(0, 5) == 0);
         if (r < rounds - 1) begin
            if (w_inst) rand_inst();
            else rand_data();
         end
      end
      serve(!w_inst, $urandom_range(1, TO + 2), $urandom, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      clk_en = 1'b1;
      inst_rd_en = 1'b0;
      inst_addr = 32'd0;
      data_rd_en = 1'b0;
      data_wr_en = 1'b0;
      data_addr = 32'd0;
      data_wr = 32'd0;
      data_rd_wr_ctrl = 2'b10;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_irdy", 32'(inst_ready), 32'd0);
      check("rst_drdy", 32'(data_ready), 32'd0);
      check("rst_err", 32'(bus_error), 32'd0);
      check("rst_be", 32'(mem_be), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      rst = 1'b0;
      step();
      last_data = 1'b0;

      set_inst(32'h0000_0100);
      serve(1'b1, 3, 32'h0000_0013, 1'b0);
      set_data(1'b1, 32'h0000_0203, 2'b00, 32'h0000_00AB);
      serve(1'b0, 1, 32'd0, 1'b0);
      set_data(1'b0, 32'h0000_0002, 2'b01, 32'd0);
      serve(1'b0, 2, 32'hBEEF_0000, 1'b0);
      set_data(1'b0, 32'h0000_0040, 2'b10, 32'd0);
      serve(1'b0, 99, 32'd0, 1'b0);
      set_data(1'b0, 32'h0000_0003, 2'b10, 32'd0);
      serve(1'b0, 1, 32'd0, 1'b0);
      set_data(1'b1, 32'h0000_0010, 2'b11, 32'h1234_5678);
      serve(1'b0, 1, 32'd0, 1'b0);
      set_inst(32'h0000_0104);
      serve(1'b1, TO, 32'hCAFE_F00D, 1'b0);
      set_inst(32'h0000_0108);
      serve(1'b1, 2, 32'h0000_0033, 1'b1);
      pair_rounds(3);

      for (int i = 0; i < 25; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               rand_inst();
               serve(1'b1, $urandom_range(1, TO + 2), $urandom, $urandom_range(0, 5) == 0);
            end
            1: begin
               rand_data();
               serve(1'b0, $urandom_range(1, TO + 2), $urandom, $urandom_range(0, 5) == 0);
            end
            default: pair_rounds($urandom_range(1, 3));
         endcase
      end

      set_inst(32'h0000_0300);
      step();
      check("midrst_req_before", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_req", 32'(mem_req), 32'd0);
      check("midrst_irdy", 32'(inst_ready), 32'd0);
      inst_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_data = 1'b0;
      step();
      check("postrst_irdy", 32'(inst_ready), 32'd0);
      check("postrst_req", 32'(mem_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: memory cycles to wait for mem_ack before aborting; legal range 1..65535.
REQ-002 Parameter RR_EN, default 1: 1 = round-robin when both requesters pend; 0 = fixed data priority.
REQ-003 clk  in  1  Clock; one clock domain; all state updates on the rising edge.
REQ-004 rst  in  1  Reset; asynchronous assert; active-high.
REQ-005 clk_en  in  1  Clock enable; when 0, all state holds.
REQ-006 inst_rd_en  in  1  Instruction read request; level signal; held until inst_ready.
REQ-007 inst_addr  in  32  Instruction address; word aligned; stable while requesting.
REQ-008 inst_ready  out  1  One-cycle pulse; inst_data valid.
REQ-009 inst_data  out  32  Registered instruction word.
REQ-010 data_rd_en / data_wr_en  in  1 each  Data read/write request; level; mutually exclusive.
REQ-011 data_addr  in  32  Data byte address.
REQ-012 data_wr  in  32  Store data, LSB-justified.
REQ-013 data_rd_wr_ctrl  in  2  Size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-014 data_ready  out  1  One-cycle pulse; data access complete.
REQ-015 data_rd  out  32  Registered, lane-aligned load word (sign/zero extension happens downstream).
REQ-016 mem_req  out  1  Memory request; held until mem_ack.
REQ-017 mem_we  out  1  Write strobe qualifying mem_req.
REQ-018 mem_addr  out  32  Word address; bits [1:0] forced to 0.
REQ-019 mem_be  out  4  Byte enables.
REQ-020 mem_wdata  out  32  Store data replicated onto byte lanes.
REQ-021 mem_ack  in  1  One-cycle completion pulse; mem_rdata valid with it.
REQ-022 mem_rdata  in  32  Read data.
REQ-023 bus_error  out  1  One-cycle pulse; timeout or misalignment; goes to the control exception input.

Function
REQ-024 FSM states: IDLE, INST_BUSY, DATA_BUSY, RESP.
REQ-025 IDLE to INST_BUSY/DATA_BUSY: on the grant decision; mem_req, mem_addr, mem_be, mem_we and mem_wdata are registered and assert on the next cycle.
REQ-026 Both requests pending with RR_EN=1: grant the requester not served last; the last-grant flag resets to "inst", so data wins the first tie.
REQ-027 Both requests pending with RR_EN=0: data always wins.
REQ-028 BUSY to RESP: on mem_ack; mem_req deasserts in the same cycle; rdata is captured.
REQ-029 RESP: pulse the granted ready for exactly one cycle, then return to IDLE.
REQ-030 Minimum latency: request seen in cycle N, mem_req at N+1, ack at N+1 gives ready at N+2.
REQ-031 Requester handshake: a requester still asserting in the cycle after its ready pulse counts as a new request.
REQ-032 mem_be by size and addr[1:0]:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
REQ-033 mem_wdata replication: byte {4{b}}, half {2{h}}, word unchanged.
REQ-034 Load data on data_rd: shifted right by 8*addr[1:0] so the addressed byte is at [7:0].
REQ-035 Misalignment is any of: half with addr[0]=1, word with addr[1:0]!=00, inst_addr[1:0]!=00, or ctrl=11. Response:
  - no memory cycle is issued;
  - bus_error and the requester's ready pulse in the same cycle;
  - the state passes through RESP.
REQ-036 Timeout counter (16 bits): clears on grant; increments each BUSY cycle.
REQ-037 Timeout abort, when the counter reaches TIMEOUT_CYCLES without ack:
  - drop mem_req;
  - pulse bus_error and the ready;
  - return read data 0;
  - go to RESP.
REQ-038 mem_ack in IDLE or RESP is ignored.
REQ-039 mem_ack in the same cycle as the timeout: the ack wins and bus_error does not assert.
REQ-040 A request that drops while BUSY does not cancel the memory cycle; its ready still pulses.
REQ-041 clk_en=0 freezes the FSM, counter and outputs; ready pulses are not lost or duplicated.

Reset
REQ-042 rst=1 asynchronously forces the state to IDLE; all outputs, the counter and the last-grant flag go to 0.
REQ-043 rst asserted mid-transaction abandons the transaction with no ready pulse; memory-side recovery is the system's responsibility.

Structure
REQ-044 The shared package holds:
  - arbState_e (the four states);
  - memSize_e (BYTE/HALF/WORD);
  - the constant MEM_ADDR_ALIGN_MASK;
  - existing types dataBus_u and instruction_u are reused.
REQ-045 The lane logic (mem_be, wdata replication, rdata shift, misalign detect) is a combinational sub-module named mem_lane_align.

Verification
REQ-046 Single inst read: addr 0x100, ack after 3 cycles with rdata 0x00000013 -> inst_ready at ack+1, inst_data 0x00000013, mem_be 1111.
REQ-047 Simultaneous requests, RR_EN=1, both held -> grants alternate data, inst, data; no ready pulse overlap.
REQ-048 Byte store: addr 0x203, data_wr 0xAB -> mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x200, mem_we=1.
REQ-049 Half load: addr 0x2 -> mem_be 1100; rdata 0xBEEF0000 -> data_rd[15:0] 0xBEEF.
REQ-050 No ack, TIMEOUT_CYCLES=4 -> bus_error plus data_ready pulse 4 cycles after mem_req rises, data_rd 0, mem_req low.
REQ-051 Word load at addr 0x3 -> no mem_req; bus_error and data_ready in the same cycle.
